// File: rtl/muldiv_pkg.sv
// Shared types for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN_DEF = 32;
  localparam int CNT_W    = $clog2(XLEN_DEF);

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_div(input op_t op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign fixup.
module muldiv_signfix #(
  parameter int W = 32
) (
  input  logic         neg_i,
  input  logic [W-1:0] val_i,
  output logic [W-1:0] val_o
);

  assign val_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] dataA,
  input  logic [XLEN-1:0] dataB,
  output logic            req_ready,
  output logic            busy,
  output logic            resp_valid,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  state_t              state_q, state_d;
  op_t                 op_q, op_d;
  logic                neg_q, neg_d;
  logic                special_q, special_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic                resp_valid_q, resp_valid_d;
  logic [XLEN-1:0]     result_q, result_d;

  op_t                 op_in;
  logic                sa, sb, div_zero, div_ovf;
  logic [XLEN-1:0]     mag_a, mag_b, spec_res;
  logic [XLEN:0]       mul_sum, div_trial, div_diff;
  logic                div_ge;
  logic [2*XLEN-1:0]   mul_next, div_next, res_raw, res_fixed;
  logic [XLEN-1:0]     res_word;

  assign op_in = op_t'(req_op);
  assign sa = dataA[XLEN-1] & (op_in inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
  assign sb = dataB[XLEN-1] & (op_in inside {OP_MUL, OP_MULH, OP_DIV, OP_REM});
  assign div_zero = is_div(op_in) && (dataB == '0);
  assign div_ovf  = (op_in inside {OP_DIV, OP_REM}) &&
                    (dataA == {1'b1, {(XLEN-1){1'b0}}}) && (dataB == '1);
  // op[1] distinguishes REM/REMU from DIV/DIVU
  assign spec_res = div_zero ? (op_in[1] ? dataA : '1) : (op_in[1] ? '0 : dataA);

  muldiv_signfix #(.W(XLEN)) u_fix_a (.neg_i(sa), .val_i(dataA), .val_o(mag_a));
  muldiv_signfix #(.W(XLEN)) u_fix_b (.neg_i(sb), .val_i(dataB), .val_o(mag_b));

  // Multiply: multiplier sits in the low half and shifts out as partial sums shift in.
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

  // Divide: high half is the partial remainder, low half the dividend turning into the quotient.
  assign div_trial = acc_q[2*XLEN-1:XLEN-1];
  assign div_diff  = div_trial - {1'b0, b_q};
  assign div_ge    = ~div_diff[XLEN];
  assign div_next  = {(div_ge ? div_diff[XLEN-1:0] : div_trial[XLEN-1:0]),
                      acc_q[XLEN-2:0], div_ge};

  always_comb begin
    res_raw = acc_q;
    if (is_div(op_q)) begin
      res_raw = op_q[1] ? {{XLEN{1'b0}}, acc_q[2*XLEN-1:XLEN]}
                        : {{XLEN{1'b0}}, acc_q[XLEN-1:0]};
    end
  end

  muldiv_signfix #(.W(2*XLEN)) u_fix_res (.neg_i(neg_q), .val_i(res_raw), .val_o(res_fixed));

  always_comb begin
    res_word = res_fixed[XLEN-1:0];
    if (special_q) begin
      res_word = acc_q[XLEN-1:0];
    end else if (op_q inside {OP_MULH, OP_MULHSU, OP_MULHU}) begin
      res_word = res_fixed[2*XLEN-1:XLEN];
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    neg_d        = neg_q;
    special_d    = special_q;
    cnt_d        = cnt_q;
    b_d          = b_q;
    acc_d        = acc_q;
    resp_valid_d = 1'b0;
    result_d     = result_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d  = op_in;
          neg_d = (is_div(op_in) && op_in[1]) ? sa : (sa ^ sb);
          if (div_zero || div_ovf) begin
            special_d = 1'b1;
            acc_d     = {{XLEN{1'b0}}, spec_res};
            state_d   = DONE;
          end else begin
            special_d = 1'b0;
            acc_d     = {{XLEN{1'b0}}, mag_a};
            b_d       = mag_b;
            cnt_d     = CW'(XLEN-1);
            state_d   = CALC;
          end
        end
      end
      CALC: begin
        acc_d = is_div(op_q) ? div_next : mul_next;
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        result_d     = res_word;
        resp_valid_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      op_q         <= OP_MUL;
      neg_q        <= 1'b0;
      special_q    <= 1'b0;
      cnt_q        <= '0;
      b_q          <= '0;
      acc_q        <= '0;
      resp_valid_q <= 1'b0;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      neg_q        <= neg_d;
      special_q    <= special_d;
      cnt_q        <= cnt_d;
      b_q          <= b_d;
      acc_q        <= acc_d;
      resp_valid_q <= resp_valid_d;
      result_q     <= result_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign resp_valid = resp_valid_q;
  assign result     = result_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit; the responder to the datapath's multi-cycle ALU issue and ready handshake.
- The datapath presents operands and an M-extension op. It stalls the PC until this block returns a result with a single-cycle completion pulse.
- One operation is in flight at a time. Shift-add multiply and restoring divide each take one bit per cycle.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  datapath issues an operation this cycle.
- req_op  input  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- dataA  input  XLEN  rs1 operand (multiplicand / dividend).
- dataB  input  XLEN  rs2 operand (multiplier / divisor).
- req_ready  output  1  high only in IDLE; a request is accepted when req_valid && req_ready.
- busy  output  1  high in CALC and DONE.
- resp_valid  output  1  single-cycle completion pulse.
- result  output  XLEN  operation result; valid when resp_valid is high, held until the next accept.

Behaviour:
- Reset (async, any state): state IDLE, req_ready=1, busy=0, resp_valid=0, result=0, iteration counter=0, internal operand registers=0. An operation in progress is abandoned with no response.
- States and transitions:
  - IDLE: on accept, latch op, sign flags and operand magnitudes, then go to CALC. Special division cases go directly to DONE instead.
  - CALC: perform one iteration per cycle; the counter counts XLEN-1 down to 0. At 0, go to DONE.
  - DONE: resp_valid=1 for exactly one cycle with result registered; go to IDLE.
- Latency: accept on edge N; resp_valid high in cycle N+XLEN+1 (33 cycles after accept for XLEN=32). Special-case latency: resp_valid in cycle N+1.
- req_valid while not IDLE is ignored: not queued, no side effect. Operands and op are sampled only at accept; later input changes have no effect.
- Sign handling:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: dataA signed, dataB unsigned.
  - MULHU/DIVU/REMU: both unsigned.
  - Magnitudes are taken at accept. Product is negated iff the operand signs differ. Quotient sign is sA^sB. Remainder sign is sA.
- Multiply: 2*XLEN-bit unsigned shift-add accumulator. MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits after sign fixup.
- Divide: restoring, XLEN+1-bit subtractor, one quotient bit per cycle.
- Divide special cases (RISC-V defined, no trap):
  - Divisor 0: DIV/DIVU give all-ones; REM/REMU give dataA.
  - Signed overflow (dataA=0x80000000, dataB=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
  - Multiply by 0 takes the full iteration path; there is no early exit.
- After DONE, result is stable through IDLE until the next accept. A back-to-back accept is allowed in the IDLE cycle immediately following DONE.

Decomposition:
- Package muldiv_pkg:
  - typedef enum for op codes matching funct3 (OP_MUL..OP_REMU).
  - typedef enum state_t {IDLE, CALC, DONE}.
  - localparam for the counter width, $clog2(XLEN).
  - helper function is_div(op).
- Sub-module muldiv_signfix: combinational conditional two's-complement negate. Instantiated for operand magnitude at accept and for result fixup at DONE.

Test Plan:
- Reset mid-CALC: accept DIV, assert rst at cycle 10 -> req_ready=1, busy=0, result=0, no resp_valid afterwards.
- MUL dataA=0xFFFFFFFF (-1), dataB=7 -> resp_valid exactly 33 cycles after accept, result=0xFFFFFFF9; MULH same operands -> 0xFFFFFFFF; MULHU -> 0x00000006.
- DIV dataA=-7 (0xFFFFFFF9), dataB=2 -> 0xFFFFFFFD (-3); REM same -> 0xFFFFFFFF (-1); DIVU 100/7 -> 14; REMU -> 2.
- Divide by zero DIVU 0x1234/0 -> 0xFFFFFFFF, REM 0x1234/0 -> 0x1234, both with resp_valid one cycle after accept; overflow DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
- Handshake: hold req_valid high with changing operands during CALC -> only the first request executes, result unaffected; a second request accepted in the IDLE cycle after DONE completes correctly.
- MULHSU dataA=0x80000000, dataB=0xFFFFFFFF -> 0x80000000; result held stable for 5 idle cycles after resp_valid.
